// File: rtl/run_detect_sched.sv
// Round-robin arbiter that time-shares one serial run-length detector between
// N_REQ frame requesters and reports a hit count per frame.
//
// state  | meaning
// IDLE   | waiting for any REQ; grants round-robin from ptr
// SHIFT  | DATA_W cycles, one frame bit per cycle into the detector
// REPORT | DONE pulse, per-frame result published
module run_detect_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int RUN_LEN = 4,
  localparam int ID_W   = $clog2(N_REQ),
  localparam int CNT_W  = $clog2(DATA_W + 1),
  localparam int RUN_W  = $clog2(RUN_LEN + 1)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ*DATA_W-1:0]   DATA,
  output logic [N_REQ-1:0]          ACK,
  output logic                      BUSY,
  output logic                      SER_BIT,
  output logic                      DONE,
  output logic [ID_W-1:0]           DONE_ID,
  output logic                      HIT,
  output logic [CNT_W-1:0]          HIT_CNT,
  output logic [1:0]                STATE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b10,
    ST_REPORT = 2'b11
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cur_id;
  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic [RUN_W-1:0]  run;
  logic [CNT_W-1:0]  acc;

  logic [DATA_W-1:0] frame_arr [N_REQ];
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   ptr_next;
  logic              first_bit;
  logic [RUN_W-1:0]  run_next;
  logic              det;
  logic [CNT_W-1:0]  acc_next;

  assign STATE = state;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      frame_arr[i] = DATA[i*DATA_W +: DATA_W];
    end
  end

  // first set request at or after ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (!gnt_found && REQ[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    ptr_next = ID_W'((int'(gnt_id) + 1) % N_REQ);
  end

  // detector update for the bit currently on SER_BIT
  always_comb begin
    first_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    if (first_bit || (SER_BIT != last_bit)) begin
      run_next = RUN_W'(1);
    end else if (run == RUN_W'(RUN_LEN)) begin
      run_next = run;
    end else begin
      run_next = run + RUN_W'(1);
    end
    det      = (run_next == RUN_W'(RUN_LEN));
    acc_next = acc + CNT_W'(det);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cur_id   <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
      run      <= '0;
      acc      <= '0;
      ACK      <= '0;
      BUSY     <= 1'b0;
      SER_BIT  <= 1'b0;
      DONE     <= 1'b0;
      DONE_ID  <= '0;
      HIT      <= 1'b0;
      HIT_CNT  <= '0;
    end else begin
      ACK  <= '0;
      DONE <= 1'b0;
      case (state)
        ST_SHIFT: begin
          last_bit <= SER_BIT;
          run      <= run_next;
          acc      <= acc_next;
          if (bit_cnt == '0) begin
            state   <= ST_REPORT;
            SER_BIT <= 1'b0;
            DONE    <= 1'b1;
            DONE_ID <= cur_id;
            HIT     <= (acc_next != '0);
            HIT_CNT <= acc_next;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            SER_BIT <= sh[DATA_W-1];
            sh      <= sh << 1;
          end
        end
        ST_REPORT: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        // IDLE, and the unused 01 encoding, behave identically
        default: begin
          state <= ST_IDLE;
          if (gnt_found) begin
            state    <= ST_SHIFT;
            BUSY     <= 1'b1;
            ACK      <= N_REQ'(1) << gnt_id;
            SER_BIT  <= frame_arr[gnt_id][DATA_W-1];
            sh       <= frame_arr[gnt_id] << 1;
            bit_cnt  <= CNT_W'(DATA_W - 1);
            last_bit <= 1'b0;
            run      <= '0;
            acc      <= '0;
            cur_id   <= gnt_id;
            ptr      <= ptr_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_detect_sched.sv
// Directed bench for run_detect_sched: reset, single frames, bit patterns,
// round-robin ordering, detector isolation between frames, mid-frame reset.
module tb_run_detect_sched;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  REQ;
  logic [31:0] DATA;
  logic [3:0]  ACK;
  logic        BUSY;
  logic        SER_BIT;
  logic        DONE;
  logic [1:0]  DONE_ID;
  logic        HIT;
  logic [3:0]  HIT_CNT;
  logic [1:0]  STATE;

  int n_checks = 0;
  int n_fail   = 0;

  run_detect_sched #(.N_REQ(4), .DATA_W(8), .RUN_LEN(4)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .DATA(DATA), .ACK(ACK),
    .BUSY(BUSY), .SER_BIT(SER_BIT), .DONE(DONE), .DONE_ID(DONE_ID),
    .HIT(HIT), .HIT_CNT(HIT_CNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},     32'(ACK),     32'h0);
    check({tag, "_busy"},    32'(BUSY),    32'h0);
    check({tag, "_ser"},     32'(SER_BIT), 32'h0);
    check({tag, "_done"},    32'(DONE),    32'h0);
    check({tag, "_done_id"}, 32'(DONE_ID), 32'h0);
    check({tag, "_hit"},     32'(HIT),     32'h0);
    check({tag, "_hit_cnt"}, 32'(HIT_CNT), 32'h0);
    check({tag, "_state"},   32'(STATE),   32'h0);
  endtask

  // One frame from a lone requester; REQ dropped in the ACK cycle.
  task automatic send(input string tag, input int id, input logic [7:0] frame,
                      input int exp_cnt);
    REQ  = 4'(1 << id);
    DATA[id*8 +: 8] = frame;
    tick();
    check({tag, "_ack"}, 32'(ACK), 32'(1 << id));
    REQ = 4'b0000;
    repeat (8) tick();
    check({tag, "_done"},    32'(DONE),    32'h1);
    check({tag, "_done_id"}, 32'(DONE_ID), 32'(id));
    check({tag, "_hit_cnt"}, 32'(HIT_CNT), 32'(exp_cnt));
    check({tag, "_hit"},     32'(HIT),     32'(exp_cnt != 0));
    tick();
    check({tag, "_idle"},    32'(STATE),   32'h0);
  endtask

  // Waits for the next ACK; returns cycles taken (budget 20).
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ACK == 4'b0000 && n < 20);
  endtask

  initial begin
    logic [7:0] exp_bits;
    int n;

    RESET = 1'b1;
    REQ   = 4'b0000;
    DATA  = 32'h0;

    // asynchronous reset, observed before any clock edge
    #2 RESET = 1'b0;
    #1 check_idle_outputs("rst_async");
    tick();
    tick();
    RESET = 1'b1;
    tick();
    check_idle_outputs("rst_held");

    // round-robin with all requesters active, ptr starts at 0
    DATA = 32'hAA_F0_FF_06;
    REQ  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(n);
      check("rr_ack", 32'(ACK), 32'(1 << (g % 4)));
      check("rr_gap", 32'(n), (g == 0) ? 32'd1 : 32'd10);
      if (g == 4) REQ = 4'b0000;
    end
    repeat (9) tick();
    check("rr_end_state", 32'(STATE), 32'h0);

    // single frame with bit-by-bit serial check; DATA changed after capture
    exp_bits = 8'b0000_0110;
    REQ = 4'b0100;
    DATA[23:16] = exp_bits;
    tick();
    check("single_ack",   32'(ACK),     32'h4);
    check("single_state", 32'(STATE),   32'h2);
    check("single_busy",  32'(BUSY),    32'h1);
    check("single_bit0",  32'(SER_BIT), 32'(exp_bits[7]));
    REQ = 4'b0000;
    DATA[23:16] = 8'hFF;
    for (int k = 1; k < 8; k++) begin
      tick();
      check("single_ack_clear", 32'(ACK), 32'h0);
      check("single_ser", 32'(SER_BIT), 32'(exp_bits[7-k]));
    end
    tick();
    check("single_done",    32'(DONE),    32'h1);
    check("single_done_id", 32'(DONE_ID), 32'h2);
    check("single_hit",     32'(HIT),     32'h1);
    check("single_hit_cnt", 32'(HIT_CNT), 32'h2);
    check("single_report",  32'(STATE),   32'h3);
    check("single_ser_rep", 32'(SER_BIT), 32'h0);
    tick();
    check("single_done_pulse", 32'(DONE),    32'h0);
    check("single_idle",       32'(STATE),   32'h0);
    check("single_busy_low",   32'(BUSY),    32'h0);
    check("single_hold_cnt",   32'(HIT_CNT), 32'h2);
    check("single_hold_id",    32'(DONE_ID), 32'h2);

    // bit patterns
    send("pat_aa", 0, 8'hAA, 0);
    send("pat_ff", 1, 8'hFF, 5);
    send("pat_f0", 3, 8'hF0, 2);

    // detector must not carry a trailing run into the next frame
    send("carry_07", 1, 8'h07, 2);
    send("carry_e0", 1, 8'hE0, 2);

    // reset during SHIFT cycle 4 drops the frame
    REQ = 4'b1000;
    DATA[31:24] = 8'hFF;
    tick();
    check("midrst_ack", 32'(ACK), 32'h8);
    REQ = 4'b0000;
    repeat (4) tick();
    check("midrst_shift", 32'(STATE), 32'h2);
    #1 RESET = 1'b0;
    #1 check_idle_outputs("midrst_async");
    REQ = 4'b1010;
    tick();
    check("midrst_no_done", 32'(DONE), 32'h0);
    RESET = 1'b1;
    wait_ack(n);
    check("post_rst_ack1", 32'(ACK), 32'h2);
    check("post_rst_lat",  32'(n),   32'd1);
    REQ = 4'b1000;
    wait_ack(n);
    check("post_rst_ack3", 32'(ACK), 32'h8);
    check("post_rst_gap",  32'(n),   32'd10);
    REQ = 4'b0000;
    repeat (8) tick();
    check("post_rst_done_id", 32'(DONE_ID), 32'h3);
    check("post_rst_hit_cnt", 32'(HIT_CNT), 32'h5);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
